// File: rtl/banco_registros_param.sv
// Parametrised MIPS register bank: two combinational read ports, one write port,
// built-in clear sweep after reset or on request, optional zero register and bypass.
module banco_registros_param #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] Read_Reg1,
   input  logic [ADDR_W-1:0] Read_Reg2,
   input  logic [ADDR_W-1:0] Write_Reg,
   input  logic [DATA_W-1:0] Write_Data,
   input  logic              RegWrite,
   input  logic              Clear,
   output logic [DATA_W-1:0] Read_data1,
   output logic [DATA_W-1:0] Read_data2,
   output logic              Ready
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              ready_q;
   logic [DATA_W-1:0] br_q [DEPTH];
   logic              wr_en;

   assign wr_en = RegWrite && (state_q == IDLE) && !Clear
                  && !(ZERO_REG && (Write_Reg == '0));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (Clear) begin
                  state_q <= CLEAR;
                  cnt_q   <= '0;
                  ready_q <= 1'b0;
               end
            end
            CLEAR: begin
               if (cnt_q == '1) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  ready_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= CLEAR;
               cnt_q   <= '0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   // Storage has no reset; the sweep zeroes it one entry per edge.
   always_ff @(posedge clk) begin
      if (state_q == CLEAR) begin
         br_q[cnt_q] <= '0;
      end else if (wr_en) begin
         br_q[Write_Reg] <= Write_Data;
      end
   end

   function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] v;
      v = br_q[a];
      if (!ready_q) begin
         v = '0;
      end else if (ZERO_REG && (a == '0)) begin
         v = '0;
      end else if (BYPASS && wr_en && (Write_Reg == a)) begin
         v = Write_Data;
      end
      return v;
   endfunction

   always_comb begin
      Read_data1 = rd(Read_Reg1);
      Read_data2 = rd(Read_Reg2);
   end

   assign Ready = ready_q;

endmodule

// File: tb/tb_banco_registros_param.sv
// Scoreboard bench for banco_registros_param: expectations queued at drive time,
// popped and compared once the combinational outputs settle.
module tb_banco_registros_param;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  Read_Reg1, Read_Reg2, Write_Reg;
   logic [31:0] Write_Data;
   logic        RegWrite, Clear;
   logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
   logic        rdy, nb_rdy;

   int n_chk  = 0;
   int n_pass = 0;

   string       tag_q [$];
   int          sel_q [$];
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   banco_registros_param u_dut (
      .clk(clk), .reset(reset),
      .Read_Reg1(Read_Reg1), .Read_Reg2(Read_Reg2),
      .Write_Reg(Write_Reg), .Write_Data(Write_Data),
      .RegWrite(RegWrite), .Clear(Clear),
      .Read_data1(rd1), .Read_data2(rd2), .Ready(rdy)
   );

   banco_registros_param #(.BYPASS(1'b0)) u_nobyp (
      .clk(clk), .reset(reset),
      .Read_Reg1(Read_Reg1), .Read_Reg2(Read_Reg2),
      .Write_Reg(Write_Reg), .Write_Data(Write_Data),
      .RegWrite(RegWrite), .Clear(Clear),
      .Read_data1(nb_rd1), .Read_data2(nb_rd2), .Ready(nb_rdy)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic push(input string tag, input int sel, input logic [31:0] e);
      tag_q.push_back(tag);
      sel_q.push_back(sel);
      exp_q.push_back(e);
   endtask

   task automatic settle();
      logic [31:0] obs;
      #1;
      while (exp_q.size() > 0) begin
         unique case (sel_q[0])
            0: obs = {31'd0, rdy};
            1: obs = rd1;
            2: obs = rd2;
            3: obs = nb_rd1;
            default: obs = {31'd0, nb_rdy};
         endcase
         chk(tag_q.pop_front(), obs, exp_q.pop_front());
         void'(sel_q.pop_front());
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      RegWrite = 1'b1; Write_Reg = a; Write_Data = d;
      @(posedge clk);
      @(negedge clk);
      RegWrite = 1'b0;
   endtask

   task automatic sweep(input string tag, input bit poke);
      for (int j = 1; j <= 32; j++) begin
         @(posedge clk);
         @(negedge clk);
         Clear = poke && (j == 10);
         push(tag, 0, {31'd0, j == 32});
         push({tag, "_nb"}, 4, {31'd0, j == 32});
         if (j < 32) begin
            push({tag, "_rd1"}, 1, 32'd0);
            push({tag, "_rd2"}, 2, 32'd0);
         end
         settle();
      end
   endtask

   initial begin
      reset = 1'b0; RegWrite = 1'b0; Clear = 1'b0;
      Read_Reg1 = 5'd4; Read_Reg2 = 5'd9;
      Write_Reg = 5'd0; Write_Data = 32'd0;
      #2 reset = 1'b1;
      push("rst_ready", 0, 32'd0);
      push("rst_rd1", 1, 32'd0);
      push("rst_rd2", 2, 32'd0);
      settle();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      sweep("boot_ready", 1'b0);

      for (int a = 0; a < 32; a++) begin
         Read_Reg1 = 5'(a);
         Read_Reg2 = 5'(31 - a);
         push("init_rd1", 1, 32'd0);
         push("init_rd2", 2, 32'd0);
         settle();
      end

      wr(5'd5, 32'hDEADBEEF);
      wr(5'd31, 32'h00000001);
      Read_Reg1 = 5'd5; Read_Reg2 = 5'd31;
      push("wr_r5", 1, 32'hDEADBEEF);
      push("wr_r31", 2, 32'h00000001);
      push("wr_r5_nb", 3, 32'hDEADBEEF);
      settle();

      @(negedge clk);
      RegWrite = 1'b1; Write_Reg = 5'd0; Write_Data = 32'hFFFFFFFF;
      Read_Reg1 = 5'd0; Read_Reg2 = 5'd0;
      push("zero_now1", 1, 32'd0);
      push("zero_now2", 2, 32'd0);
      settle();
      @(posedge clk);
      @(negedge clk);
      RegWrite = 1'b0;
      push("zero_next1", 1, 32'd0);
      push("zero_next2", 2, 32'd0);
      settle();

      wr(5'd7, 32'h11111111);
      RegWrite = 1'b1; Write_Reg = 5'd7; Write_Data = 32'h22222222;
      Read_Reg1 = 5'd7;
      push("byp_same", 1, 32'h22222222);
      push("nobyp_same", 3, 32'h11111111);
      settle();
      @(posedge clk);
      @(negedge clk);
      RegWrite = 1'b0;
      push("byp_after", 1, 32'h22222222);
      push("nobyp_after", 3, 32'h22222222);
      settle();

      wr(5'd3, 32'h00000033);
      Clear = 1'b1; RegWrite = 1'b1; Write_Reg = 5'd3; Write_Data = 32'h0000ABCD;
      Read_Reg1 = 5'd3; Read_Reg2 = 5'd5;
      @(posedge clk);
      @(negedge clk);
      Clear = 1'b0; RegWrite = 1'b0;
      push("clr_k_ready", 0, 32'd0);
      push("clr_k_rd1", 1, 32'd0);
      settle();
      sweep("clr_ready", 1'b1);
      push("clr_r3", 1, 32'd0);
      push("clr_r5", 2, 32'd0);
      push("clr_r3_nb", 3, 32'd0);
      settle();

      Clear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      Clear = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      push("midrst_ready", 0, 32'd0);
      settle();
      @(negedge clk);
      reset = 1'b0;
      sweep("midrst_ready", 1'b0);

      wr(5'd12, 32'h0BADF00D);
      Read_Reg1 = 5'd12;
      push("post_r12", 1, 32'h0BADF00D);
      push("post_r12_nb", 3, 32'h0BADF00D);
      settle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/banco_registros_param.md
# banco_registros_param

Parametrised, clocked successor to the MIPS register bank. It provides two combinational read ports and one synchronous write port, with optional hardwired-zero register 0 and optional write-to-read bypass. A built-in clear sequencer zeroes every entry after reset or on request, so the bank needs no preload file. It sits between instruction decode and the ALU operand muxes of the 32-bit MIPS datapath.

## Interface
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; depth DEPTH = 2**ADDR_W.
- ZERO_REG, 1: 1 = entry 0 always reads 0 and ignores writes.
- BYPASS, 1: 1 = a same-cycle write to an address being read is forwarded to that read port.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- Read_Reg1  in  ADDR_W  read port 1 address.
- Read_Reg2  in  ADDR_W  read port 2 address.
- Write_Reg  in  ADDR_W  write address.
- Write_Data  in  DATA_W  write data.
- RegWrite  in  1  write enable, sampled on clk.
- Clear  in  1  request to zero all entries, sampled on clk.
- Read_data1  out  DATA_W  port 1 data, combinational.
- Read_data2  out  DATA_W  port 2 data, combinational.
- Ready  out  1  1 = bank idle and usable.

## Operation
- Two states, IDLE and CLEAR, plus a clear counter cnt of ADDR_W bits.
- Reset asserted: state = CLEAR, cnt = 0, Ready = 0, Read_data1/2 = 0.
  - Storage is not reset directly; the sweep clears it.
- CLEAR, each edge:
  - BR[cnt] = 0 and cnt increments.
  - At cnt == DEPTH-1, that edge clears the last entry and moves to IDLE.
- IDLE, Clear = 1 at an edge: state = CLEAR, cnt = 0.
  - Clear has priority over a simultaneous RegWrite; the write is dropped.
- CLEAR ignores Clear (no restart) and ignores RegWrite.
- Reset during a sweep restarts it from cnt = 0.
- Write condition: RegWrite && state == IDLE && !Clear && !(ZERO_REG && Write_Reg == 0). When true, BR[Write_Reg] = Write_Data on the edge.
- Read, port N:
  - If !Ready: 0.
  - Else if ZERO_REG && Read_RegN == 0: 0.
  - Else if BYPASS && write condition true && Write_Reg == Read_RegN: Write_Data.
  - Otherwise: BR[Read_RegN].
- Both ports may read the same address; both follow the same rules.
- No arithmetic on data; widths pass through unchanged. cnt wraps only via the state change, never past DEPTH-1.

## Timing
- Read latency: zero cycles, combinational from addresses, stored contents, Ready, and the bypass inputs.
- Write latency: one edge.
  - Without bypass, written data is visible on a read after the edge.
  - With bypass, it is visible in the same cycle.
- After reset deasserts, the first rising edge clears entry 0.
  - Ready rises after edge DEPTH (32 by default).
- Clear sampled at edge k:
  - Ready = 0 after edge k.
  - Entries cleared on edges k+1 through k+DEPTH.
  - Ready = 1 after edge k+DEPTH.
- Ready is registered and changes only on clk edges or asynchronously on reset.

## Test plan
- Reset then idle: assert reset, release, count edges.
  - Ready = 0 through edge 31 and 1 after edge 32.
  - Read_data1/2 = 0 throughout.
  - All 32 entries read 0.
- Basic write/read: write 0xDEADBEEF to reg 5, then 0x00000001 to reg 31; read 5 and 31 on the next cycle.
  - Required: 0xDEADBEEF and 0x00000001.
- Zero register: write 0xFFFFFFFF to reg 0 and read reg 0 on both ports.
  - Required: 0 on both, in the same cycle and the next.
- Bypass: reg 7 holds 0x11111111; RegWrite = 1 with Write_Reg = 7, Write_Data = 0x22222222, Read_Reg1 = 7.
  - Required: Read_data1 = 0x22222222 in the same cycle.
  - With BYPASS = 0: 0x11111111 before the edge, 0x22222222 after.
- Clear collision: in IDLE, assert Clear and a RegWrite of 0xABCD to reg 3 in the same cycle; reassert Clear mid-sweep.
  - Ready = 0 for exactly 32 edges.
  - Reg 3 reads 0 afterwards.
  - Reads are 0 during the sweep.
- Reset mid-sweep: assert reset at cnt = 10 and release.
  - Ready rises exactly 32 edges after release.
